// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters and the data memory.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/host arbiter in front of one single-port data memory (IDLE/ISSUE/WAIT/ACK).
// Optional macro ARB_CPU_PRIORITY_EN: CPU wins every tie instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] crd_q;
    logic [DATA_W-1:0] hrd_q;
    logic              any_req;
    logic              grant;

    assign any_req = bus.cpu_req | bus.host_req;

`ifdef ARB_CPU_PRIORITY_EN
    // host is granted only when the CPU is not asking
    assign grant = ~bus.cpu_req;
`else
    logic last_q;

    assign grant = (bus.cpu_req & bus.host_req) ? ~last_q : bus.host_req;

    // remember who was served last; host after reset so the CPU wins the first tie
    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (state == ACK)
            last_q <= owner_q;
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (any_req) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (cnt == 4'd0) state_nx = ACK;
            ACK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // latch the winner, count the memory latency, capture read data
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crd_q   <= '0;
            hrd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= grant;
                        we_q    <= grant ? bus.host_we : bus.cpu_we;
                        addr_q  <= grant ? bus.host_addr : bus.cpu_addr;
                        wdata_q <= grant ? bus.host_wdata : bus.cpu_wdata;
                    end
                end
                ISSUE: cnt <= LAT_M1;
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!we_q) begin
                        if (owner_q)
                            hrd_q <= bus.mem_rdata;
                        else
                            crd_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en     = (state == ISSUE);
    assign bus.mem_we     = (state == ISSUE) & we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = (state != IDLE);
    assign bus.owner      = owner_q;
    assign bus.cpu_ack    = (state == ACK) & ~owner_q;
    assign bus.host_ack   = (state == ACK) & owner_q;
    assign bus.cpu_rdata  = crd_q;
    assign bus.host_rdata = hrd_q;
endmodule
